mxn_logic_pipe: RTL

Runtime-selectable, pipelined successor to the fixed-operation mXn bitwise gates. It processes SETS lanes of WIDTH bits and selects NOT/AND/OR/NAND/NOR/XOR/XNOR per transaction through an opcode. It uses a valid/ready handshake and a per-lane enable mask. It sits between the operand registers and the ALU result mux as the logic-unit datapath.

---
 rtl/mxn_logic_pkg.sv | 22 ++
 rtl/mxn_logic_lane.sv | 41 ++++
 rtl/mxn_logic_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/mxn_logic_pkg.sv
// Shared opcode encoding for the mXn logic-unit datapath.
// Imported by the lane compute cell and the pipeline top.
package mxn_logic_pkg;

   localparam int OP_W = 3;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_NOT     = 3'd0;
   localparam op_t OP_AND     = 3'd1;
   localparam op_t OP_OR      = 3'd2;
   localparam op_t OP_NAND    = 3'd3;
   localparam op_t OP_NOR     = 3'd4;
   localparam op_t OP_XOR     = 3'd5;
   localparam op_t OP_XNOR    = 3'd6;
   localparam op_t OP_ILLEGAL = 3'd7;

   function automatic logic op_is_illegal(input op_t op);
      return op == OP_ILLEGAL;
   endfunction

endpackage

// File: rtl/mxn_logic_lane.sv
// One WIDTH-bit lane of the logic unit: selects a bitwise gate by opcode.
// Purely combinational; disabled lanes forward operand a, illegal op forces zero.
module mxn_logic_lane
   import mxn_logic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [OP_W-1:0]  op,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] w_gate;

   always_comb begin
      w_gate = '0;
      case (op)
         OP_NOT:  w_gate = ~a;
         OP_AND:  w_gate = a & b;
         OP_OR:   w_gate = a | b;
         OP_NAND: w_gate = ~(a & b);
         OP_NOR:  w_gate = ~(a | b);
         OP_XOR:  w_gate = a ^ b;
         OP_XNOR: w_gate = ~(a ^ b);
         default: w_gate = '0;
      endcase
   end

   // Illegal opcode wins over the enable so an error result is always all-zero.
   always_comb begin
      y = w_gate;
      if (op_is_illegal(op)) begin
         y = '0;
      end else if (!en) begin
         y = a;
      end
   end

endmodule

// File: rtl/mxn_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit over SETS lanes; optional MXN_LOGIC_ZFLAG_EN adds per-lane zero flags.
// Latency 2 cycles, 1/cycle throughput; in_ready is a combinational chain from out_ready (no skid buffer).
module mxn_logic_pipe
   import mxn_logic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SETS  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_W-1:0]       op,
   input  logic [SETS-1:0]       lane_en,
   input  logic [SETS*WIDTH-1:0] in1_packed,
   input  logic [SETS*WIDTH-1:0] in2_packed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SETS*WIDTH-1:0] out_packed,
`ifdef MXN_LOGIC_ZFLAG_EN
   output logic [SETS-1:0]       zero_flags,
`endif
   output logic                  op_err
);

   logic                  r_s1_vld;
   logic [OP_W-1:0]       r_s1_op;
   logic [SETS-1:0]       r_s1_en;
   logic [SETS*WIDTH-1:0] r_s1_a;
   logic [SETS*WIDTH-1:0] r_s1_b;

   logic                  r_s2_vld;
   logic [SETS*WIDTH-1:0] r_s2_dat;
   logic                  r_s2_err;

   logic                  w_s1_adv;
   logic                  w_s2_adv;
   logic                  w_acc;
   logic [SETS*WIDTH-1:0] w_res;
   logic                  w_err;

   assign w_s2_adv = !r_s2_vld || out_ready;
   assign w_s1_adv = !r_s1_vld || w_s2_adv;
   assign in_ready = w_s1_adv;
   assign w_acc    = in_valid && w_s1_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_op  <= '0;
         r_s1_en  <= '0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
      end else if (w_s1_adv) begin
         r_s1_vld <= in_valid;
         if (w_acc) begin
            r_s1_op <= op;
            r_s1_en <= lane_en;
            r_s1_a  <= in1_packed;
            r_s1_b  <= in2_packed;
         end
      end
   end

   for (genvar g = 0; g < SETS; g++) begin : g_lane
      mxn_logic_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .op (r_s1_op),
         .en (r_s1_en[g]),
         .a  (r_s1_a[g*WIDTH +: WIDTH]),
         .b  (r_s1_b[g*WIDTH +: WIDTH]),
         .y  (w_res[g*WIDTH +: WIDTH])
      );
   end

   assign w_err = op_is_illegal(r_s1_op);

   // S2 payload only changes when it advances, so outputs stay put under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_s2_dat <= '0;
         r_s2_err <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_dat <= w_res;
            r_s2_err <= w_err;
         end
      end
   end

`ifdef MXN_LOGIC_ZFLAG_EN
   logic [SETS-1:0] w_zf;
   logic [SETS-1:0] r_s2_zf;

   for (genvar z = 0; z < SETS; z++) begin : g_zf
      assign w_zf[z] = ~|w_res[z*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_zf <= '0;
      end else if (w_s2_adv && r_s1_vld) begin
         r_s2_zf <= w_zf;
      end
   end

   assign zero_flags = r_s2_zf;
`endif

   assign out_valid  = r_s2_vld;
   assign out_packed = r_s2_dat;
   assign op_err     = r_s2_err;

endmodule
